// File: rtl/mem_port_arbiter_if.sv
// Fetch/LSU request side and bridge-facing memory side of the shared port.
// master: requesters plus bridge; slave: the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  localparam int MW = DATA_WIDTH / 8;

  logic                  i_ren;
  logic [ADDR_WIDTH-1:0] i_raddr;
  logic                  i_rvalid;
  logic [DATA_WIDTH-1:0] i_rdata;

  logic                  d_ren;
  logic [ADDR_WIDTH-1:0] d_raddr;
  logic                  d_wen;
  logic [ADDR_WIDTH-1:0] d_waddr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [MW-1:0]         d_wmask;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_wvalid;

  logic                  m_ren;
  logic [ADDR_WIDTH-1:0] m_raddr;
  logic                  m_wen;
  logic [ADDR_WIDTH-1:0] m_waddr;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic [MW-1:0]         m_wmask;
  logic                  m_rvalid;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic                  m_wvalid;

  modport master (
    output i_ren, i_raddr,
    output d_ren, d_raddr,
    output d_wen, d_waddr, d_wdata, d_wmask,
    output m_rvalid, m_rdata, m_wvalid,
    input  i_rvalid, i_rdata,
    input  d_rvalid, d_rdata, d_wvalid,
    input  m_ren, m_raddr,
    input  m_wen, m_waddr, m_wdata, m_wmask
  );

  modport slave (
    input  i_ren, i_raddr,
    input  d_ren, d_raddr,
    input  d_wen, d_waddr, d_wdata, d_wmask,
    input  m_rvalid, m_rdata, m_wvalid,
    output i_rvalid, i_rdata,
    output d_rvalid, d_rdata, d_wvalid,
    output m_ren, m_raddr,
    output m_wen, m_waddr, m_wdata, m_wmask
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the bridge's single read/write port between fetch and LSU.
// One transaction in flight; writes beat reads, reads round-robin.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic               clk,
  input  logic               rstn,
  mem_port_arbiter_if.slave  bus,
  output logic               busy,
  output logic [1:0]         owner
);
  localparam int MW = DATA_WIDTH / 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] WAIT_R = 2'd2;
  localparam logic [1:0] WAIT_W = 2'd3;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_I    = 2'b01;
  localparam logic [1:0] OWN_DR   = 2'b10;
  localparam logic [1:0] OWN_DW   = 2'b11;

  logic [1:0]            state;
  logic [1:0]            own_q;
  logic                  last_d;
  logic                  ren_q;
  logic                  wen_q;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [MW-1:0]         wmask_q;

  logic       wr_req;
  logic       rd_i;
  logic       rd_d;
  logic [1:0] gnt;

  // last_d set means data was granted last, so fetch wins a read tie
  assign wr_req = bus.d_wen;
  assign rd_i   = !wr_req && bus.i_ren &&
                  (!bus.d_ren || last_d);
  assign rd_d   = !wr_req && bus.d_ren && !rd_i;

  always_comb begin
    gnt = OWN_NONE;
    unique case (1'b1)
      wr_req:  gnt = OWN_DW;
      rd_i:    gnt = OWN_I;
      rd_d:    gnt = OWN_DR;
      default: gnt = OWN_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      own_q   <= OWN_NONE;
      last_d  <= 1'b1;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      raddr_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      ren_q <= 1'b0;
      wen_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt != OWN_NONE) begin
            own_q  <= gnt;
            last_d <= (gnt != OWN_I);
            state  <= ISSUE;
            if (gnt == OWN_DW) begin
              wen_q   <= 1'b1;
              waddr_q <= bus.d_waddr;
              wdata_q <= bus.d_wdata;
              wmask_q <= bus.d_wmask;
            end else begin
              ren_q   <= 1'b1;
              raddr_q <= (gnt == OWN_I) ?
                         bus.i_raddr : bus.d_raddr;
            end
          end
        end
        ISSUE: begin
          state <= (own_q == OWN_DW) ? WAIT_W : WAIT_R;
        end
        WAIT_R: begin
          if (bus.m_rvalid) begin
            state <= IDLE;
            own_q <= OWN_NONE;
          end
        end
        WAIT_W: begin
          if (bus.m_wvalid) begin
            state <= IDLE;
            own_q <= OWN_NONE;
          end
        end
        default: begin
          state <= IDLE;
          own_q <= OWN_NONE;
        end
      endcase
    end
  end

  assign bus.m_ren   = ren_q;
  assign bus.m_wen   = wen_q;
  assign bus.m_raddr = raddr_q;
  assign bus.m_waddr = waddr_q;
  assign bus.m_wdata = wdata_q;
  assign bus.m_wmask = wmask_q;

  assign bus.i_rvalid = (state == WAIT_R) &&
                        (own_q == OWN_I) && bus.m_rvalid;
  assign bus.d_rvalid = (state == WAIT_R) &&
                        (own_q == OWN_DR) && bus.m_rvalid;
  assign bus.d_wvalid = (state == WAIT_W) && bus.m_wvalid;
  assign bus.i_rdata  = bus.m_rdata;
  assign bus.d_rdata  = bus.m_rdata;

  assign busy  = (state != IDLE);
  assign owner = own_q;
endmodule
